instr_fetch: RTL and testbench

Instruction fetch and prefetch stage that sits directly upstream of `processador` and drives its `iin` instruction input. It reads 16-bit instruction words from a synchronous instruction ROM, buffers them in a small FIFO and presents them one at a time under a valid/take handshake. A `jump` input redirects fetch and flushes every buffered or in-flight word. Instruction encoding is opaque to this block: `iin[15:13]` opcode, `[12:10]` rX, `[9:0]` immediate or rY.

---
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch / prefetch stage.
// Streams 16-bit words from a synchronous ROM (one-cycle read latency) into
// a small FIFO and presents the head under a valid/take handshake. A jump
// redirects the fetch pointer and flushes every buffered and in-flight word.
module instr_fetch #(
  parameter int                 ADDR_W     = 8,
  parameter int                 DEPTH      = 4,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0
) (
  input  logic              clock,
  input  logic              resetn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_data,
  output logic [15:0]       iin,
  output logic              iin_valid,
  input  logic              iin_take,
  output logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  typedef enum logic {S_RESET, S_RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fa;             // fetch pointer
  logic [CNT_W-1:0]  cnt;            // buffered entries
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              inflight;       // a read was issued last cycle
  logic [ADDR_W-1:0] inflight_addr;  // address of that read

  logic [15:0]       fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];

  logic              run;
  logic [CNT_W:0]    occ;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign run       = (state == S_RUN);
  // Occupancy counts the in-flight word so a response always has a slot;
  // a same-cycle take is deliberately not credited.
  assign occ       = {1'b0, cnt} + (CNT_W + 1)'(inflight);
  assign mem_rd    = run && !jump && (occ < DEPTH_OCC);
  assign mem_addr  = fa;
  assign iin_valid = (cnt != '0);
  // A jump discards the arriving response and ignores a simultaneous take.
  assign push      = run && inflight && !jump;
  assign pop       = run && iin_valid && iin_take && !jump;

  // Head presentation, forced to zero while the FIFO is empty
  always_comb begin
    // NOTE: blocking (=) here because this is combinational; the clocked
    // blocks below use non-blocking (<=) so every register samples old values.
    // NOTE: both outputs get a default first so no path can infer a latch.
    iin = '0;
    pc  = '0;
    if (iin_valid) begin
      iin = fifo_data[rd_ptr];
      pc  = fifo_addr[rd_ptr];
    end
  end

  // Control state: FSM, fetch pointer, FIFO pointers/count, in-flight tracking
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= S_RESET;
      fa            <= START_ADDR;
      cnt           <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      inflight      <= 1'b0;
      inflight_addr <= START_ADDR;
    end else begin
      case (state)
        S_RESET: state <= S_RUN;
        S_RUN: begin
          if (jump) begin
            fa       <= jump_addr;
            cnt      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
          end else begin
            inflight <= mem_rd;
            if (mem_rd) begin
              fa            <= fa + ADDR_W'(1);
              inflight_addr <= fa;
            end
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
              2'b10:   cnt <= cnt + CNT_W'(1);
              2'b01:   cnt <= cnt - CNT_W'(1);
              default: cnt <= cnt;
            endcase
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

  // FIFO storage write port
  // NOTE: storage is not reset; cnt gates what is visible, so stale words
  // never reach the outputs and the array can map onto plain RAM cells.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_data;
      fifo_addr[wr_ptr] <= inflight_addr;
    end
  end

  // The read-issue rule must make an overflowing push impossible.
  no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(push && !pop && cnt == CNT_FULL));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a scoreboard checks every consumed
// instruction, a per-cycle vector table covers backpressure, and short
// hand-written sequences cover redirect, jump+take, wrap-around and async reset.
module tb_instr_fetch;

  typedef struct packed {
    logic        valid;
    logic [15:0] iin;
    logic [7:0]  pc;
    logic        rd;
    logic [7:0]  addr;
  } out_t;

  typedef struct packed {
    logic take;
    out_t exp;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  addr;
  } exp_t;

  logic        clock;
  logic        resetn;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic [15:0] iin;
  logic        iin_valid;
  logic        iin_take;
  logic [7:0]  pc;
  logic        jump;
  logic [7:0]  jump_addr;

  logic        resetn_w;
  logic [7:0]  mem_addr_w;
  logic        mem_rd_w;
  logic [15:0] mem_data_w;
  logic [15:0] iin_w;
  logic        iin_valid_w;
  logic [7:0]  pc_w;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  instr_fetch #(.ADDR_W(8), .DEPTH(4), .START_ADDR(8'h00)) dut (
    .clock(clock), .resetn(resetn), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .iin(iin), .iin_valid(iin_valid), .iin_take(iin_take),
    .pc(pc), .jump(jump), .jump_addr(jump_addr)
  );

  instr_fetch #(.ADDR_W(8), .DEPTH(4), .START_ADDR(8'hFE)) dut_wrap (
    .clock(clock), .resetn(resetn_w), .mem_addr(mem_addr_w), .mem_rd(mem_rd_w),
    .mem_data(mem_data_w), .iin(iin_w), .iin_valid(iin_valid_w), .iin_take(1'b1),
    .pc(pc_w), .jump(1'b0), .jump_addr(8'h00)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    case (a)
      8'h00:   return 16'hA01C;
      8'h01:   return 16'hA40A;
      8'h02:   return 16'h2080;
      8'h03:   return 16'h8000;
      8'h40:   return 16'hA3FF;
      default: return {8'h5A, a};
    endcase
  endfunction

  // Synchronous ROMs: data one cycle after the read strobe, junk otherwise
  always @(posedge clock) begin
    mem_data   <= mem_rd   ? rom_word(mem_addr)   : 16'hDEAD;
    mem_data_w <= mem_rd_w ? rom_word(mem_addr_w) : 16'hDEAD;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic out_t mk(input logic v, input logic [15:0] d, input logic [7:0] p,
                              input logic r, input logic [7:0] a);
    return {v, d, p, r, a};
  endfunction

  task automatic sb_load(input logic [7:0] start, input int n);
    logic [7:0] a;
    sb.delete();
    a = start;
    for (int i = 0; i < n; i++) begin
      sb.push_back({rom_word(a), a});
      a = a + 8'd1;
    end
  endtask

  // One clock cycle: drive inputs just after the edge, sample at the falling edge
  task automatic tick(input logic take, input logic jmp, input logic [7:0] jaddr,
                      output out_t o);
    iin_take  = take;
    jump      = jmp;
    jump_addr = jaddr;
    @(negedge clock);
    o = {iin_valid, iin, pc, mem_rd, mem_addr};
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    iin_take = 1'b0;
    jump     = 1'b0;
    sb.delete();
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  // Scoreboard: every consumed head must match the next expected word
  always @(negedge clock) begin
    exp_t e;
    if (resetn && iin_valid && iin_take && !jump) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got pc=%0h iin=%0h expected no take", pc, iin);
      end else begin
        e = sb.pop_front();
        check("sb_iin", iin, e.data);
        check("sb_pc", pc, e.addr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    out_t        o;
    vec_t        tbl[$];
    logic [7:0]  wrap_exp[4];
    logic [7:0]  rd_seen[4];
    logic [7:0]  pc_seen[4];
    logic [15:0] iin_seen[4];
    int          nrd;
    int          npc;

    resetn    = 1'b0;
    resetn_w  = 1'b0;
    iin_take  = 1'b0;
    jump      = 1'b0;
    jump_addr = 8'h00;
    @(posedge clock); #1;

    // Reset state
    tick(1'b0, 1'b0, 8'h00, o);
    check("rst_valid", o.valid, 1'b0);
    check("rst_iin",   o.iin,   16'h0000);
    check("rst_pc",    o.pc,    8'h00);
    check("rst_rd",    o.rd,    1'b0);
    check("rst_addr",  o.addr,  8'h00);

    // Basic stream: k=0 is the release cycle, k=1 is C0, valid from C2
    do_reset();
    sb_load(8'h00, 16);
    for (int k = 0; k < 12; k++) begin
      tick(1'b1, 1'b0, 8'h00, o);
      check($sformatf("stream_valid_k%0d", k), o.valid, (k >= 3));
      if (k == 0) check("stream_rd_release", o.rd, 1'b0);
      if (k == 1) check("stream_c0_read", {o.rd, o.addr}, {1'b1, 8'h00});
    end

    // Backpressure table
    do_reset();
    sb_load(8'h00, 4);
    tbl.delete();
    tbl.push_back({1'b0, mk(1'b0, 16'h0000, 8'h00, 1'b0, 8'h00)});
    tbl.push_back({1'b0, mk(1'b0, 16'h0000, 8'h00, 1'b1, 8'h00)});
    tbl.push_back({1'b0, mk(1'b0, 16'h0000, 8'h00, 1'b1, 8'h01)});
    tbl.push_back({1'b0, mk(1'b1, 16'hA01C, 8'h00, 1'b1, 8'h02)});
    tbl.push_back({1'b0, mk(1'b1, 16'hA01C, 8'h00, 1'b1, 8'h03)});
    for (int i = 0; i < 21; i++)
      tbl.push_back({1'b0, mk(1'b1, 16'hA01C, 8'h00, 1'b0, 8'h04)});
    tbl.push_back({1'b1, mk(1'b1, 16'hA01C, 8'h00, 1'b0, 8'h04)});
    tbl.push_back({1'b0, mk(1'b1, 16'hA40A, 8'h01, 1'b1, 8'h04)});
    tbl.push_back({1'b0, mk(1'b1, 16'hA40A, 8'h01, 1'b0, 8'h05)});
    tbl.push_back({1'b0, mk(1'b1, 16'hA40A, 8'h01, 1'b0, 8'h05)});
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].take, 1'b0, 8'h00, o);
      check($sformatf("bp_row%0d", i), o, tbl[i].exp);
    end

    // Redirect with 3 buffered entries and a read in flight
    do_reset();
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 8'h00, o);
    tick(1'b0, 1'b1, 8'h40, o);
    check("redir_j_head", {o.valid, o.iin, o.rd}, {1'b1, 16'hA01C, 1'b0});
    sb_load(8'h40, 8);
    tick(1'b0, 1'b0, 8'h00, o);
    check("redir_j1", {o.valid, o.rd, o.addr}, {1'b0, 1'b1, 8'h40});
    tick(1'b0, 1'b0, 8'h00, o);
    check("redir_j2", {o.valid, o.rd, o.addr}, {1'b0, 1'b1, 8'h41});
    tick(1'b1, 1'b0, 8'h00, o);
    check("redir_j3", {o.valid, o.iin, o.pc}, {1'b1, 16'hA3FF, 8'h40});
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 8'h00, o);

    // Jump with simultaneous take
    do_reset();
    sb_load(8'h00, 16);
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 8'h00, o);
    sb_load(8'h80, 8);
    tick(1'b1, 1'b1, 8'h80, o);
    check("jt_j_head", {o.valid, o.pc, o.rd}, {1'b1, 8'h02, 1'b0});
    tick(1'b1, 1'b0, 8'h00, o);
    check("jt_j1", {o.valid, o.rd, o.addr}, {1'b0, 1'b1, 8'h80});
    tick(1'b1, 1'b0, 8'h00, o);
    check("jt_j2_valid", o.valid, 1'b0);
    tick(1'b1, 1'b0, 8'h00, o);
    check("jt_j3", {o.valid, o.iin, o.pc}, {1'b1, rom_word(8'h80), 8'h80});
    for (int k = 0; k < 2; k++) tick(1'b1, 1'b0, 8'h00, o);

    // Async reset mid-stream
    do_reset();
    sb_load(8'h00, 16);
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b0, 8'h00, o);
    check("ar_before", {o.valid, o.rd}, {1'b1, 1'b1});
    iin_take = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("ar_valid", iin_valid, 1'b0);
    check("ar_rd",    mem_rd,    1'b0);
    check("ar_iin",   iin,       16'h0000);
    check("ar_pc",    pc,        8'h00);
    check("ar_addr",  mem_addr,  8'h00);
    #1 resetn = 1'b1;
    sb_load(8'h00, 16);
    @(posedge clock); #1;
    tick(1'b1, 1'b0, 8'h00, o);
    check("ar_c0", {o.valid, o.rd, o.addr}, {1'b0, 1'b1, 8'h00});
    tick(1'b1, 1'b0, 8'h00, o);
    check("ar_c1_valid", o.valid, 1'b0);
    tick(1'b1, 1'b0, 8'h00, o);
    check("ar_c2", {o.valid, o.iin, o.pc}, {1'b1, 16'hA01C, 8'h00});
    tick(1'b1, 1'b0, 8'h00, o);

    // Wrap-around on the START_ADDR=0xFE instance
    iin_take = 1'b0;
    jump     = 1'b0;
    wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    rd_seen  = '{default: 8'h00};
    pc_seen  = '{default: 8'h00};
    iin_seen = '{default: 16'h0000};
    nrd = 0;
    npc = 0;
    resetn_w = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (mem_rd_w && nrd < 4) begin
        rd_seen[nrd] = mem_addr_w;
        nrd++;
      end
      if (iin_valid_w && npc < 4) begin
        pc_seen[npc]  = pc_w;
        iin_seen[npc] = iin_w;
        npc++;
      end
      @(posedge clock); #1;
    end
    check("wrap_nrd", nrd, 4);
    check("wrap_npc", npc, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_rd%0d", i),  rd_seen[i],  wrap_exp[i]);
      check($sformatf("wrap_pc%0d", i),  pc_seen[i],  wrap_exp[i]);
      check($sformatf("wrap_iin%0d", i), iin_seen[i], rom_word(wrap_exp[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
